seq_addsub_sm: RTL and testbench

- Parametrised, multi-cycle add/subtract unit. Successor to the 4-bit combinational sign-magnitude subtractor.
- Processes operands CHUNK bits per clock through one shared CHUNK-bit ripple adder, so area stays fixed as WIDTH grows.
- Subtract mode returns |a-b| plus a negative flag. Add mode returns the sum plus a carry-out.
- Sits between the ALU operand registers and the result mux, with a valid/ready handshake on both sides.

---
 rtl/seq_addsub_sm_if.sv | 35 +++
 rtl/seq_addsub_sm.sv | 119 +++++++++++
 tb/tb_seq_addsub_sm.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_addsub_sm_if.sv
// Handshake and data bundle for seq_addsub_sm.
// With SEQ_ADDSUB_ZERO_FLAG_EN defined, the bundle also carries the zero-result flag.
interface seq_addsub_sm_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] mag;
    logic             neg;
    logic             cout;
`ifdef SEQ_ADDSUB_ZERO_FLAG_EN
    logic             zero;
`endif

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, mag, neg, cout
`ifdef SEQ_ADDSUB_ZERO_FLAG_EN
        , zero
`endif
    );

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, mag, neg, cout
`ifdef SEQ_ADDSUB_ZERO_FLAG_EN
        , zero
`endif
    );
endinterface

// File: rtl/seq_addsub_sm.sv
// Multi-cycle sign-magnitude add/subtract through one shared CHUNK-bit adder, LSB chunk first.
// Optional SEQ_ADDSUB_ZERO_FLAG_EN adds a registered zero-result flag.
module seq_addsub_sm #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input logic            clk,
    input logic            rst_n,
    seq_addsub_sm_if.slave bus
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, DIFF, FIX, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] ra, rb, acc, acc_nxt;
    logic             op_r, carry, neg_r, cout_r;
    logic [CW-1:0]    cnt;
    logic [CHUNK-1:0] x, y;
    logic [CHUNK:0]   sum;
    logic             last;
`ifdef SEQ_ADDSUB_ZERO_FLAG_EN
    logic             zero_r;
    assign bus.zero = zero_r;
`endif

    // One adder serves both passes: a + (b or ~b) in DIFF, ~acc + carry in FIX.
    always_comb begin
        x = ra[CHUNK-1:0];
        y = op_r ? rb[CHUNK-1:0] : ~rb[CHUNK-1:0];
        if (state == FIX) begin
            x = ~acc[CHUNK-1:0];
            y = '0;
        end
        sum     = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, carry};
        acc_nxt = (acc >> CHUNK) | (WIDTH'(sum[CHUNK-1:0]) << (WIDTH - CHUNK));
        last    = (cnt == CW'(N - 1));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.in_valid) state_nxt = DIFF;
            DIFF: if (last) state_nxt = (!op_r && !sum[CHUNK]) ? FIX : DONE;
            FIX:  if (last) state_nxt = DONE;
            DONE: if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.mag       = acc;
    assign bus.neg       = neg_r;
    assign bus.cout      = cout_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ra     <= '0;
            rb     <= '0;
            acc    <= '0;
            op_r   <= 1'b0;
            carry  <= 1'b0;
            neg_r  <= 1'b0;
            cout_r <= 1'b0;
            cnt    <= '0;
`ifdef SEQ_ADDSUB_ZERO_FLAG_EN
            zero_r <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (bus.in_valid) begin
                    ra     <= bus.a;
                    rb     <= bus.b;
                    op_r   <= bus.op;
                    carry  <= ~bus.op;
                    cnt    <= '0;
                    neg_r  <= 1'b0;
                    cout_r <= 1'b0;
`ifdef SEQ_ADDSUB_ZERO_FLAG_EN
                    zero_r <= 1'b0;
`endif
                end
                DIFF: begin
                    acc   <= acc_nxt;
                    ra    <= ra >> CHUNK;
                    rb    <= rb >> CHUNK;
                    carry <= sum[CHUNK];
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        cnt <= '0;
                        // No final carry on a subtract means a<b: negate back to a magnitude.
                        if (!op_r && !sum[CHUNK]) begin
                            neg_r <= 1'b1;
                            carry <= 1'b1;
                        end else begin
                            cout_r <= op_r & sum[CHUNK];
`ifdef SEQ_ADDSUB_ZERO_FLAG_EN
                            zero_r <= (acc_nxt == '0);
`endif
                        end
                    end
                end
                FIX: begin
                    acc   <= acc_nxt;
                    carry <= sum[CHUNK];
                    cnt   <= cnt + 1'b1;
`ifdef SEQ_ADDSUB_ZERO_FLAG_EN
                    if (last) zero_r <= (acc_nxt == '0);
`endif
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_addsub_sm.sv
// Scoreboard bench for seq_addsub_sm at WIDTH=8, CHUNK=4.
// Build with SEQ_ADDSUB_ZERO_FLAG_EN to also check the zero flag.
module tb_seq_addsub_sm;
    localparam int WIDTH = 8;
    localparam int CHUNK = 4;
    localparam int N     = WIDTH / CHUNK;

    typedef struct packed {
        logic [WIDTH-1:0] mag;
        logic             neg;
        logic             cout;
        logic             zero;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    exp_t sb[$];

    seq_addsub_sm_if #(.WIDTH(WIDTH)) bus();
    seq_addsub_sm #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    function automatic exp_t model(input logic op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t e;
        logic [WIDTH:0] s;
        e = '0;
        if (op) begin
            s = {1'b0, a} + {1'b0, b};
            e.mag  = s[WIDTH-1:0];
            e.cout = s[WIDTH];
        end else begin
            e.neg = (a < b);
            e.mag = e.neg ? (b - a) : (a - b);
        end
        e.zero = (e.mag == '0);
        return e;
    endfunction

    function automatic exp_t pop_exp();
        if (sb.size() == 0) return '1;
        return sb.pop_front();
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int w = 0;
        while (!bus.in_ready && w < 50) begin
            tick();
            w++;
        end
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL send_ready: in_ready=%b want 1", bus.in_ready);
        end
        bus.in_valid = 1'b1;
        bus.op = op;
        bus.a = a;
        bus.b = b;
        sb.push_back(model(op, a, b));
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Latency counted from the accept cycle; -1 when out_valid never arrives.
    task automatic wait_out(output int lat, output logic rdy_seen);
        lat = 1;
        rdy_seen = 1'b0;
        while (!bus.out_valid && lat < 40) begin
            if (bus.in_ready) rdy_seen = 1'b1;
            tick();
            lat++;
        end
        if (!bus.out_valid) lat = -1;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.op = 1'b0; bus.a = '0; bus.b = '0; bus.out_ready = 1'b1;
        #12;
        total++;
        if ({bus.in_ready, bus.out_valid, bus.mag, bus.neg, bus.cout} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_state: rdy=%b ov=%b mag=%h neg=%b cout=%b want 1 0 00 0 0",
                     bus.in_ready, bus.out_valid, bus.mag, bus.neg, bus.cout);
        end
`ifdef SEQ_ADDSUB_ZERO_FLAG_EN
        total++;
        if (bus.zero !== 1'b0) begin bad++; $display("FAIL reset_zero: got %b want 0", bus.zero); end
`endif
        #5 rst_n = 1'b1;
        tick();
    endtask

    task automatic run_one(input string name, input logic op, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b, input int want_lat);
        int lat;
        logic rdy;
        exp_t e;
        send(op, a, b);
        wait_out(lat, rdy);
        e = pop_exp();
        total += 3;
        if (lat != want_lat) begin bad++; $display("FAIL %s_latency: got %0d want %0d", name, lat, want_lat); end
        if (rdy !== 1'b0) begin bad++; $display("FAIL %s_busy_ready: in_ready seen %b want 0", name, rdy); end
        if ({bus.mag, bus.neg, bus.cout} !== {e.mag, e.neg, e.cout}) begin
            bad++;
            $display("FAIL %s_result: got mag=%h neg=%b cout=%b want mag=%h neg=%b cout=%b",
                     name, bus.mag, bus.neg, bus.cout, e.mag, e.neg, e.cout);
        end
`ifdef SEQ_ADDSUB_ZERO_FLAG_EN
        total++;
        if (bus.zero !== e.zero) begin bad++; $display("FAIL %s_zero: got %b want %b", name, bus.zero, e.zero); end
`endif
        tick();
        total++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
            bad++;
            $display("FAIL %s_release: ov=%b rdy=%b want 0 1", name, bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_sub();
        run_one("sub_pos", 1'b0, 8'h25, 8'h13, N + 1);
        run_one("sub_neg", 1'b0, 8'h13, 8'h25, 2 * N + 1);
        run_one("sub_max", 1'b0, 8'h00, 8'hFF, 2 * N + 1);
        run_one("sub_eq", 1'b0, 8'h80, 8'h80, N + 1);
    endtask

    task automatic test_add();
        run_one("add_ovf", 1'b1, 8'hF0, 8'h20, N + 1);
        run_one("add_wrap0", 1'b1, 8'h80, 8'h80, N + 1);
        run_one("add_plain", 1'b1, 8'h12, 8'h34, N + 1);
    endtask

    task automatic test_backpressure();
        int lat;
        logic rdy;
        exp_t e;
        logic [WIDTH-1:0] m0;
        logic n0;
        bus.out_ready = 1'b0;
        send(1'b0, 8'h3C, 8'h5A);
        wait_out(lat, rdy);
        e = pop_exp();
        m0 = bus.mag;
        n0 = bus.neg;
        total++;
        if ({bus.mag, bus.neg} !== {e.mag, e.neg}) begin
            bad++;
            $display("FAIL bp_result: got mag=%h neg=%b want mag=%h neg=%b", bus.mag, bus.neg, e.mag, e.neg);
        end
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = (i == 1);
            bus.a = 8'hAA;
            bus.b = 8'h01;
            tick();
            total++;
            if ({bus.out_valid, bus.in_ready, bus.mag, bus.neg} !== {1'b1, 1'b0, m0, n0}) begin
                bad++;
                $display("FAIL bp_hold: ov=%b rdy=%b mag=%h neg=%b want 1 0 %h %b",
                         bus.out_valid, bus.in_ready, bus.mag, bus.neg, m0, n0);
            end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        total++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
            bad++;
            $display("FAIL bp_release: ov=%b rdy=%b want 0 1", bus.out_valid, bus.in_ready);
        end
        run_one("bp_next", 1'b1, 8'h0F, 8'h01, N + 1);
    endtask

    task automatic test_async_reset();
        send(1'b0, 8'h55, 8'h11);
        #3 rst_n = 1'b0;
        #1;
        total++;
        if ({bus.in_ready, bus.out_valid, bus.mag, bus.neg, bus.cout} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL async_reset: rdy=%b ov=%b mag=%h neg=%b cout=%b want 1 0 00 0 0",
                     bus.in_ready, bus.out_valid, bus.mag, bus.neg, bus.cout);
        end
        sb.delete();
        #2 rst_n = 1'b1;
        tick();
        run_one("post_reset", 1'b0, 8'h10, 8'h01, N + 1);
    endtask

    task automatic test_back_to_back();
        int issued = 0;
        int got = 0;
        int idle = 0;
        int cyc = 0;
        logic regen;
        exp_t e;
        bus.out_ready = 1'b1;
        bus.op = 1'($urandom_range(0, 1));
        bus.a = WIDTH'($urandom);
        bus.b = WIDTH'($urandom);
        bus.in_valid = 1'b1;
        while (got < 20 && cyc < 2000) begin
            regen = 1'b0;
            if (bus.out_valid) begin
                e = pop_exp();
                total += 2;
                if ({bus.mag, bus.neg, bus.cout} !== {e.mag, e.neg, e.cout}) begin
                    bad++;
                    $display("FAIL b2b_result%0d: got mag=%h neg=%b cout=%b want mag=%h neg=%b cout=%b",
                             got, bus.mag, bus.neg, bus.cout, e.mag, e.neg, e.cout);
                end
                if (idle != 1) begin bad++; $display("FAIL b2b_idle%0d: got %0d idle cycles want 1", got, idle); end
                idle = 0;
                got++;
            end
            if (bus.in_ready) begin
                idle++;
                if (issued < 20 && bus.in_valid) begin
                    sb.push_back(model(bus.op, bus.a, bus.b));
                    issued++;
                    regen = 1'b1;
                end
            end
            tick();
            cyc++;
            if (regen) begin
                if (issued == 20) bus.in_valid = 1'b0;
                else begin
                    bus.op = 1'($urandom_range(0, 1));
                    bus.a = WIDTH'($urandom);
                    bus.b = WIDTH'($urandom);
                end
            end
        end
        total++;
        if (got != 20) begin bad++; $display("FAIL b2b_count: got %0d results want 20", got); end
        bus.in_valid = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_sub();
        test_add();
        test_backpressure();
        test_async_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
